// File: rtl/i2c_master.sv
// I2C master controller: one register write or one register read per trigger.
// Each SCL bit period is split into four quarters of CLK_DIV clk cycles.
// Every bus-facing and status output comes straight from a flop.
module i2c_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [23:0] addr_data_out,
  input  logic        valid_addr_data_out,
  input  logic        I2C_trigger,
  input  logic        m_sda_i,
  output logic        m_sda_o,
  output logic        scl_o,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic        valid_data_ack,
  output logic        valid_data_ack_valid,
  output logic [7:0]  rdata_out,
  output logic        rdata_out_valid,
  output logic        PENDING_WR,
  output logic        PENDING_RD
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ACK_A, REG, ACK_R, WDATA, ACK_W,
    RSTART, ADDR_R, ACK_AR, RDATA, MNACK, STOP
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bit_q, bit_d;
  logic [23:0]   cmd_q, cmd_d;
  logic [7:0]    rshift_q, rshift_d;
  logic          trig_q, trig_d;
  logic          scl_q, scl_d;
  logic          sda_q, sda_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ack_err_q, ack_err_d;
  logic          vda_q, vda_d;
  logic          vdav_q, vdav_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          rdv_q, rdv_d;
  logic          pwr_q, pwr_d;
  logic          prd_q, prd_d;

  logic          qtr_end_s;
  logic          bit_end_s;
  logic          sample_s;
  logic [7:0]    tx_byte_s;

  // Timing strobes: end of a quarter, end of a bit period, SDA sampling point.
  always_comb begin
    qtr_end_s = (div_q == DW'(CLK_DIV - 1));
    bit_end_s = qtr_end_s && (qtr_q == 2'd3);
    sample_s  = qtr_end_s && (qtr_q == 2'd1);
  end

  // Byte currently being shifted out, selected by the transmitting state.
  always_comb begin
    case (state_q)
      ADDR:    tx_byte_s = {cmd_q[23:17], 1'b0};
      REG:     tx_byte_s = cmd_q[15:8];
      WDATA:   tx_byte_s = cmd_q[7:0];
      ADDR_R:  tx_byte_s = {cmd_q[23:17], 1'b1};
      default: tx_byte_s = 8'hFF;
    endcase
  end

  // Next-state, bit/quarter counters, command latch and status updates.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    cmd_d     = cmd_q;
    rshift_d  = rshift_q;
    trig_d    = I2C_trigger;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    vda_d     = vda_q;
    vdav_d    = 1'b0;
    rdata_d   = rdata_q;
    rdv_d     = 1'b0;
    pwr_d     = pwr_q;
    prd_d     = prd_q;

    if (state_q != IDLE) begin
      if (qtr_end_s) begin
        div_d = '0;
        qtr_d = qtr_q + 2'd1;
      end else begin
        div_d = div_q + DW'(1);
      end
    end else begin
      div_d = '0;
      qtr_d = 2'd0;
    end

    case (state_q)
      IDLE: begin
        // Only a fresh 0->1 edge with a valid command starts a transaction.
        if (I2C_trigger && !trig_q && valid_addr_data_out) begin
          cmd_d     = addr_data_out;
          state_d   = START;
          busy_d    = 1'b1;
          pwr_d     = ~addr_data_out[16];
          prd_d     = addr_data_out[16];
          ack_err_d = 1'b0;
          bit_d     = 3'd7;
        end else begin
          state_d = IDLE;
        end
      end
      START, RSTART: begin
        if (bit_end_s) begin
          state_d = (state_q == START) ? ADDR : ADDR_R;
        end else begin
          state_d = state_q;
        end
      end
      ADDR, REG, WDATA, ADDR_R, RDATA: begin
        if (sample_s && (state_q == RDATA)) begin
          rshift_d = {rshift_q[6:0], m_sda_i};
        end else begin
          rshift_d = rshift_q;
        end
        if (bit_end_s) begin
          if (bit_q == 3'd0) begin
            bit_d = 3'd7;
            case (state_q)
              ADDR:    state_d = ACK_A;
              REG:     state_d = ACK_R;
              WDATA:   state_d = ACK_W;
              ADDR_R:  state_d = ACK_AR;
              default: state_d = MNACK;
            endcase
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end else begin
          bit_d = bit_q;
        end
      end
      ACK_A, ACK_R, ACK_W, ACK_AR: begin
        if (sample_s) begin
          vda_d  = ~m_sda_i;
          vdav_d = 1'b1;
          if (m_sda_i) begin
            ack_err_d = 1'b1;
          end else begin
            ack_err_d = ack_err_q;
          end
        end else begin
          vdav_d = 1'b0;
        end
        // A NACK abandons the remaining bytes and goes straight to STOP.
        if (bit_end_s) begin
          if (ack_err_q) begin
            state_d = STOP;
          end else begin
            case (state_q)
              ACK_A:   state_d = REG;
              ACK_R:   state_d = cmd_q[16] ? RSTART : WDATA;
              ACK_AR:  state_d = RDATA;
              default: state_d = STOP;
            endcase
          end
        end else begin
          state_d = state_q;
        end
      end
      MNACK: begin
        if (bit_end_s) begin
          rdata_d = rshift_q;
          rdv_d   = 1'b1;
          state_d = STOP;
        end else begin
          state_d = MNACK;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          pwr_d   = 1'b0;
          prd_d   = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        pwr_d   = 1'b0;
        prd_d   = 1'b0;
      end
    endcase
  end

  // SCL/SDA waveform for the current state and quarter; registered below.
  always_comb begin
    case (state_q)
      START: begin
        scl_d = (qtr_q != 2'd3);
        sda_d = (qtr_q < 2'd2);
      end
      RSTART: begin
        scl_d = (qtr_q == 2'd1) || (qtr_q == 2'd2);
        sda_d = (qtr_q < 2'd2);
      end
      STOP: begin
        scl_d = (qtr_q != 2'd0);
        sda_d = (qtr_q >= 2'd2);
      end
      ADDR, REG, WDATA, ADDR_R: begin
        scl_d = (qtr_q == 2'd1) || (qtr_q == 2'd2);
        sda_d = tx_byte_s[bit_q];
      end
      ACK_A, ACK_R, ACK_W, ACK_AR, RDATA, MNACK: begin
        scl_d = (qtr_q == 2'd1) || (qtr_q == 2'd2);
        sda_d = 1'b1;
      end
      default: begin
        scl_d = 1'b1;
        sda_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q   <= IDLE;
      div_q     <= '0;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd7;
      cmd_q     <= 24'd0;
      rshift_q  <= 8'd0;
      trig_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      vda_q     <= 1'b0;
      vdav_q    <= 1'b0;
      rdata_q   <= 8'd0;
      rdv_q     <= 1'b0;
      pwr_q     <= 1'b0;
      prd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      cmd_q     <= cmd_d;
      rshift_q  <= rshift_d;
      trig_q    <= trig_d;
      scl_q     <= scl_d;
      sda_q     <= sda_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      vda_q     <= vda_d;
      vdav_q    <= vdav_d;
      rdata_q   <= rdata_d;
      rdv_q     <= rdv_d;
      pwr_q     <= pwr_d;
      prd_q     <= prd_d;
    end
  end

  assign scl_o                = scl_q;
  assign m_sda_o              = sda_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign ack_err              = ack_err_q;
  assign valid_data_ack       = vda_q;
  assign valid_data_ack_valid = vdav_q;
  assign rdata_out            = rdata_q;
  assign rdata_out_valid      = rdv_q;
  assign PENDING_WR           = pwr_q;
  assign PENDING_RD           = prd_q;

endmodule

// File: tb/tb_i2c_master.sv
// Scoreboard bench for i2c_master: a bus monitor with a small slave model and
// an output monitor pop expected events pushed by the directed stimulus.
module tb_i2c_master;

  logic        clk = 1'b0;
  logic        resetn;
  logic [23:0] addr_data_out;
  logic        valid_addr_data_out;
  logic        I2C_trigger;
  logic        m_sda_o, scl_o, busy, done, ack_err;
  logic        valid_data_ack, valid_data_ack_valid;
  logic [7:0]  rdata_out;
  logic        rdata_out_valid, PENDING_WR, PENDING_RD;
  logic        slave_sda = 1'b1;
  logic        sda_line;

  assign sda_line = m_sda_o & slave_sda;

  always #5 clk = ~clk;

  i2c_master #(.CLK_DIV(4)) dut (
    .clk(clk), .resetn(resetn),
    .addr_data_out(addr_data_out), .valid_addr_data_out(valid_addr_data_out),
    .I2C_trigger(I2C_trigger), .m_sda_i(sda_line),
    .m_sda_o(m_sda_o), .scl_o(scl_o), .busy(busy), .done(done), .ack_err(ack_err),
    .valid_data_ack(valid_data_ack), .valid_data_ack_valid(valid_data_ack_valid),
    .rdata_out(rdata_out), .rdata_out_valid(rdata_out_valid),
    .PENDING_WR(PENDING_WR), .PENDING_RD(PENDING_RD)
  );

  // Event kinds: 0 bus byte, 1 ACK-slot result, 2 read data, 3 master NACK bit,
  // 4 done (val = busy cycles, aux = ack_err, aux2 = rw).
  typedef struct {
    int kind;
    int val;
    int aux;
    int aux2;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  // Slave model configuration.
  int         nack_frame  = -1;
  logic [7:0] slave_rdata = 8'h00;

  function automatic void push(input int k, input int v, input int a, input int a2);
    ev_t e;
    e.kind = k; e.val = v; e.aux = a; e.aux2 = a2;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic match_ev(input int kind, input int val, input string name,
                          output ev_t e, output bit ok);
    total++;
    ok = 1'b0;
    e.kind = -1; e.val = 0; e.aux = 0; e.aux2 = 0;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: unexpected event, got %0h want nothing", name, val);
    end else begin
      e = exp_q.pop_front();
      ok = 1'b1;
      if (e.kind != kind || e.val != val) begin
        bad++;
        $display("FAIL %s: got kind %0d value %0h want kind %0d value %0h",
                 name, kind, val, e.kind, e.val);
      end
    end
  endtask

  // Monitor state.
  logic prev_scl = 1'b1, prev_sda = 1'b1, prev_busy = 1'b0;
  int   bit_idx = -1, frame = 0;
  bit   in_txn = 1'b0, rd_mode = 1'b0;
  logic [7:0] acc = 8'h00;
  int   busy_cnt = 0, rd_cnt = 0, wr_cnt = 0, busy_rises = 0;
  ev_t  mon_e;
  bit   mon_ok;
  logic mon_s, mon_d;

  // Bus decode, slave drive and output pulse checking, sampled on falling clk.
  always @(negedge clk) begin
    mon_s = scl_o;
    mon_d = sda_line;
    if (mon_s === 1'b1 && prev_scl === 1'b1 && mon_d !== prev_sda) begin
      if (mon_d == 1'b0) begin
        if (in_txn) rd_mode = 1'b1;
        else begin
          rd_mode = 1'b0;
          frame   = 0;
        end
        in_txn  = 1'b1;
        bit_idx = -1;
      end else begin
        in_txn = 1'b0;
      end
    end else if (mon_s && !prev_scl) begin
      if (in_txn && bit_idx >= 0 && bit_idx <= 7) begin
        acc = {acc[6:0], mon_d};
        if (bit_idx == 7) match_ev(0, int'(acc), "bus_byte", mon_e, mon_ok);
      end else if (in_txn && bit_idx == 8 && frame == 3) begin
        match_ev(3, int'(mon_d), "master_nack", mon_e, mon_ok);
      end
    end else if (!mon_s && prev_scl) begin
      if (in_txn) begin
        bit_idx++;
        if (bit_idx == 9) begin
          bit_idx = 0;
          frame++;
        end
      end
    end
    if (in_txn && bit_idx == 8 && frame <= 2)
      slave_sda = (frame == nack_frame);
    else if (in_txn && rd_mode && frame == 3 && bit_idx >= 0 && bit_idx <= 7)
      slave_sda = slave_rdata[7 - bit_idx];
    else
      slave_sda = 1'b1;
    prev_scl = mon_s;
    prev_sda = mon_d;

    if (valid_data_ack_valid) match_ev(1, int'(valid_data_ack), "ack_slot", mon_e, mon_ok);
    if (rdata_out_valid) match_ev(2, int'(rdata_out), "rdata", mon_e, mon_ok);

    if (busy && !prev_busy) begin
      busy_rises++;
      busy_cnt = 0; rd_cnt = 0; wr_cnt = 0;
    end
    if (busy) begin
      busy_cnt++;
      if (PENDING_RD && !PENDING_WR) rd_cnt++;
      if (PENDING_WR && !PENDING_RD) wr_cnt++;
    end
    prev_busy = busy;

    if (done) begin
      match_ev(4, busy_cnt, "done_busy_cycles", mon_e, mon_ok);
      if (mon_ok) begin
        chk("ack_err_at_done", int'(ack_err), mon_e.aux);
        chk("pending_during_busy", (mon_e.aux2 != 0) ? rd_cnt : wr_cnt, busy_cnt);
        chk("idle_flags_at_done", int'({busy, PENDING_WR, PENDING_RD}), 0);
      end
    end
  end

  task automatic wait_drain(input string name);
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s: timeout, got %0d pending events want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run(input logic [23:0] cmd, input bit hold, input string name);
    @(negedge clk);
    addr_data_out       = cmd;
    valid_addr_data_out = 1'b1;
    I2C_trigger         = 1'b1;
    @(negedge clk);
    if (!hold) I2C_trigger = 1'b0;
    wait_drain(name);
    repeat (4) @(negedge clk);
  endtask

  int rises_before;

  initial begin
    resetn = 1'b1; valid_addr_data_out = 1'b0; I2C_trigger = 1'b0; addr_data_out = 24'd0;
    repeat (3) @(negedge clk);
    chk("rst_scl", int'(scl_o), 1);
    chk("rst_sda", int'(m_sda_o), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ack_err", int'(ack_err), 0);
    chk("rst_vda", int'(valid_data_ack), 0);
    chk("rst_vdav", int'(valid_data_ack_valid), 0);
    chk("rst_rdata", int'(rdata_out), 0);
    chk("rst_rdv", int'(rdata_out_valid), 0);
    chk("rst_pwr", int'(PENDING_WR), 0);
    chk("rst_prd", int'(PENDING_RD), 0);
    resetn = 1'b0;
    repeat (2) @(negedge clk);

    // Plain write, all ACKed.
    push(0, 'h3A, 0, 0); push(1, 1, 0, 0); push(0, 'hBC, 0, 0); push(1, 1, 0, 0);
    push(0, 'hDD, 0, 0); push(1, 1, 0, 0); push(4, 464, 0, 0);
    run(24'h3ABCDD, 1'b0, "write");

    // Read, slave returns 0xA5.
    slave_rdata = 8'hA5;
    push(0, 'h3A, 0, 0); push(1, 1, 0, 0); push(0, 'hBC, 0, 0); push(1, 1, 0, 0);
    push(0, 'h3B, 0, 0); push(1, 1, 0, 0); push(0, 'hA5, 0, 0); push(3, 1, 0, 0);
    push(2, 'hA5, 0, 0); push(4, 624, 0, 1);
    run(24'h3BBC00, 1'b0, "read");

    // Another write; read data must hold.
    push(0, 'h2A, 0, 0); push(1, 1, 0, 0); push(0, 'h55, 0, 0); push(1, 1, 0, 0);
    push(0, 'h12, 0, 0); push(1, 1, 0, 0); push(4, 464, 0, 0);
    run(24'h2A5512, 1'b0, "write2");
    chk("rdata_hold", int'(rdata_out), 'hA5);

    // Address NACK: STOP right after the ACK slot.
    nack_frame = 0;
    push(0, 'h3A, 0, 0); push(1, 0, 0, 0); push(4, 176, 1, 0);
    run(24'h3ABCDD, 1'b0, "addr_nack");
    repeat (20) @(negedge clk);
    chk("ack_err_hold", int'(ack_err), 1);
    chk("vda_after_nack", int'(valid_data_ack), 0);

    // Clean write with trigger held high afterwards; ack_err must clear.
    nack_frame = -1;
    push(0, 'h3A, 0, 0); push(1, 1, 0, 0); push(0, 'hBC, 0, 0); push(1, 1, 0, 0);
    push(0, 'hDD, 0, 0); push(1, 1, 0, 0); push(4, 464, 0, 0);
    run(24'h3ABCDD, 1'b1, "write_held");
    rises_before = busy_rises;
    repeat (100) @(negedge clk);
    chk("held_trigger_no_restart", busy_rises - rises_before, 0);
    I2C_trigger = 1'b0;

    // Read with NACK on the register byte.
    nack_frame = 1;
    push(0, 'h3A, 0, 0); push(1, 1, 0, 0); push(0, 'hBC, 0, 0); push(1, 0, 0, 0);
    push(4, 320, 1, 1);
    run(24'h3BBC00, 1'b0, "reg_nack_read");
    nack_frame = -1;

    // Trigger edge without a valid command.
    valid_addr_data_out = 1'b0;
    rises_before = busy_rises;
    @(negedge clk);
    I2C_trigger = 1'b1;
    repeat (50) @(negedge clk);
    chk("invalid_trigger_busy", busy_rises - rises_before, 0);
    chk("invalid_trigger_bus", int'({scl_o, m_sda_o}), 3);
    I2C_trigger = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of the address byte.
    addr_data_out = 24'h3ABCDD; valid_addr_data_out = 1'b1; I2C_trigger = 1'b1;
    repeat (80) @(negedge clk);
    chk("midbyte_busy_before_reset", int'(busy), 1);
    resetn = 1'b1;
    @(negedge clk);
    chk("midrst_scl", int'(scl_o), 1);
    chk("midrst_sda", int'(m_sda_o), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_rdata", int'(rdata_out), 0);
    resetn = 1'b0; I2C_trigger = 1'b0;
    repeat (60) @(negedge clk);
    chk("after_reset_idle", int'({busy, scl_o, m_sda_o}), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per quarter SCL period; one SCL bit period = 4*CLK_DIV clk cycles.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 resetn  input  1  synchronous, active-high reset (name kept per codebase; 1 = reset).
REQ-004 addr_data_out  input  24  command word: [23:17] 7-bit slave address, [16] rw (1=read), [15:8] register byte, [7:0] write data.
REQ-005 valid_addr_data_out  input  1  addr_data_out is valid.
REQ-006 I2C_trigger  input  1  start request; rising edge sensed.
REQ-007 m_sda_i  input  1  sampled SDA line.
REQ-008 m_sda_o  output  1  SDA drive; 1 = release (open-drain high), 0 = pull low.
REQ-009 scl_o  output  1  SCL drive.
REQ-010 busy  output  1  transaction in progress.
REQ-011 done  output  1  one-cycle end-of-transaction pulse.
REQ-012 ack_err  output  1  slave NACK seen in the current/last transaction.
REQ-013 valid_data_ack  output  1  last ACK-slot result (1 = ACK, SDA sampled 0).
REQ-014 valid_data_ack_valid  output  1  one-cycle pulse qualifying valid_data_ack.
REQ-015 rdata_out  output  8  byte read from slave.
REQ-016 rdata_out_valid  output  1  one-cycle pulse qualifying rdata_out.
REQ-017 PENDING_WR  output  1  write command accepted, not yet finished.
REQ-018 PENDING_RD  output  1  read command accepted, not yet finished.

Function
REQ-019 Start: in IDLE, I2C_trigger registered 0->1 while valid_addr_data_out=1 latches addr_data_out and raises busy next cycle; a rising edge with valid=0, or any trigger while busy, is ignored; a held-high trigger starts only one transaction.
REQ-020 PENDING_WR (rw=0) or PENDING_RD (rw=1) is set with busy and cleared with busy.
REQ-021 Bit timing: quarter 0 SCL low, SDA updated; quarters 1-2 SCL high; SDA sampled at the end of quarter 1; quarter 3 SCL low; SDA never changes while SCL is high except in START/RSTART/STOP.
REQ-022 START: SDA and SCL high, SDA falls at mid-period, then SCL falls; occupies one bit period.
REQ-023 STOP: SCL low with SDA low, SCL rises, then SDA rises; occupies one bit period.
REQ-024 Write sequence: START, {addr,0}, ACK, register byte, ACK, data byte, ACK, STOP; total 29 bit periods.
REQ-025 Read sequence: START, {addr,0}, ACK, register byte, ACK, RSTART, {addr,1}, ACK, 8 data bits read, master NACK (SDA released), STOP; total 39 bit periods.
REQ-026 Bytes are sent MSB first; read data is assembled MSB first.
REQ-027 In each ACK slot the master releases SDA and samples m_sda_i; valid_data_ack = ~m_sda_i and valid_data_ack_valid pulses one cycle at sampling.
REQ-028 NACK (m_sda_i=1) in any ACK slot sets ack_err and jumps to STOP; the remaining bytes are skipped.
REQ-029 rdata_out updates and rdata_out_valid pulses one cycle at the end of the master-NACK bit of a read; rdata_out holds its value until the next read.
REQ-030 At the end of STOP: busy=0, PENDING_*=0, done pulses one cycle, state returns to IDLE.
REQ-031 ack_err clears when the next transaction is accepted; otherwise it holds.
REQ-032 States: IDLE, START, ADDR, ACK_A, REG, ACK_R, WDATA, ACK_W, RSTART, ADDR_R, ACK_AR, RDATA, MNACK, STOP.

Reset
REQ-033 resetn=1 at a clk edge forces IDLE immediately, even mid-transaction.
REQ-034 Reset values: scl_o=1, m_sda_o=1, busy=0, done=0, ack_err=0, valid_data_ack=0, valid_data_ack_valid=0, rdata_out=0, rdata_out_valid=0, PENDING_WR=0, PENDING_RD=0; trigger edge detector cleared.

Verification
REQ-035 Write 24'h3ABCDD, slave ACKs all, CLK_DIV=4 -> SDA shows bytes 0x3A, 0xBC, 0xDD; three valid_data_ack_valid pulses with ack=1; busy high 464 cycles; one done pulse; ack_err=0.
REQ-036 Read 24'h3BBC00, slave returns 0xA5 -> bytes 0x3A, 0xBC, RSTART, 0x3B; rdata_out=0xA5 with one rdata_out_valid pulse; master NACK; busy high 624 cycles; PENDING_RD high throughout.
REQ-037 Write with slave NACK on the address -> ack_err=1, valid_data_ack=0, STOP follows immediately, done pulses, busy=0.
REQ-038 I2C_trigger held high after completion -> no second transaction; a new 0->1 edge starts one.
REQ-039 resetn asserted mid-byte -> next cycle: scl_o=1, m_sda_o=1, busy=0, no done pulse.
REQ-040 Trigger edge with valid_addr_data_out=0 -> busy stays 0, bus idle.
